// File: rtl/data_write_buffer.sv
// L1D write buffer between the data-array write arbiter and the data SRAM write port.
// Coalesces back-to-back writes to the same word, drains only on read-idle cycles, and forwards pending bytes.
module data_write_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int SET_W  = 8,
    parameter int NBLK   = 4,
    parameter int NWAY   = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_req_ready,
    input  logic                io_req_valid,
    input  logic [DATA_W-1:0]   io_req_bits_data,
    input  logic [SET_W-1:0]    io_req_bits_set,
    input  logic [NBLK-1:0]     io_req_bits_blockSelOH,
    input  logic [NWAY-1:0]     io_req_bits_way,
    input  logic [DATA_W/8-1:0] io_req_bits_mask,
    input  logic                io_rd_valid,
    output logic                io_sram_wen,
    output logic [DATA_W-1:0]   io_sram_data,
    output logic [SET_W-1:0]    io_sram_set,
    output logic [NBLK-1:0]     io_sram_blockSelOH,
    output logic [NWAY-1:0]     io_sram_way,
    output logic [DATA_W/8-1:0] io_sram_mask,
    input  logic [SET_W-1:0]    io_fwd_set,
    input  logic [NBLK-1:0]     io_fwd_blockSelOH,
    input  logic [NWAY-1:0]     io_fwd_way,
    output logic                io_fwd_hit,
    output logic [DATA_W-1:0]   io_fwd_data,
    output logic [DATA_W/8-1:0] io_fwd_mask,
    output logic                io_empty
);
    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [SET_W-1:0]  set_q  [DEPTH];
    logic [NBLK-1:0]   blk_q  [DEPTH];
    logic [NWAY-1:0]   way_q  [DEPTH];
    logic [MASK_W-1:0] mask_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] young;
    logic [PTR_W-1:0] fwd_idx;
    logic [CNT_W-1:0] count_q;
    logic             fire;
    logic             drain;
    logic             young_match;
    logic             merge;
    logic             alloc;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [MASK_W-1:0] m
    );
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
        end
        return r;
    endfunction

    assign io_req_ready = (count_q != CNT_W'(DEPTH));
    assign io_empty     = (count_q == '0);
    assign fire         = io_req_valid & io_req_ready;
    assign drain        = ~io_empty & ~io_rd_valid;
    assign young        = tail_q - PTR_W'(1);
    assign young_match  = (set_q[young] == io_req_bits_set) &&
                          (blk_q[young] == io_req_bits_blockSelOH) &&
                          (way_q[young] == io_req_bits_way);
    // A youngest entry leaving for the SRAM this cycle cannot absorb the write; it gets a fresh slot.
    assign merge        = fire & ~io_empty & young_match & ~(drain & (count_q == CNT_W'(1)));
    assign alloc        = fire & ~merge;

    assign io_sram_wen        = drain;
    assign io_sram_data       = data_q[head_q];
    assign io_sram_set        = set_q[head_q];
    assign io_sram_blockSelOH = blk_q[head_q];
    assign io_sram_way        = way_q[head_q];
    assign io_sram_mask       = mask_q[head_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                set_q[i]  <= '0;
                blk_q[i]  <= '0;
                way_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            if (merge) begin
                data_q[young] <= merge_bytes(data_q[young], io_req_bits_data, io_req_bits_mask);
                mask_q[young] <= mask_q[young] | io_req_bits_mask;
            end else if (alloc) begin
                data_q[tail_q] <= io_req_bits_data;
                set_q[tail_q]  <= io_req_bits_set;
                blk_q[tail_q]  <= io_req_bits_blockSelOH;
                way_q[tail_q]  <= io_req_bits_way;
                mask_q[tail_q] <= io_req_bits_mask;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (drain) head_q <= head_q + PTR_W'(1);
            if (alloc && !drain)      count_q <= count_q + CNT_W'(1);
            else if (!alloc && drain) count_q <= count_q - CNT_W'(1);
        end
    end

    always_comb begin
        io_fwd_hit  = 1'b0;
        io_fwd_mask = '0;
        io_fwd_data = '0;
        fwd_idx     = head_q;
        // Oldest to youngest, so bytes from younger entries overwrite older ones.
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) &&
                (set_q[fwd_idx] == io_fwd_set) &&
                (blk_q[fwd_idx] == io_fwd_blockSelOH) &&
                (way_q[fwd_idx] == io_fwd_way)) begin
                io_fwd_hit  = 1'b1;
                io_fwd_mask = io_fwd_mask | mask_q[fwd_idx];
                io_fwd_data = merge_bytes(io_fwd_data, data_q[fwd_idx], mask_q[fwd_idx]);
            end
        end
    end
endmodule

// File: tb/tb_data_write_buffer.sv
// Bench for data_write_buffer: directed vector table, hand-written reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_data_write_buffer;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        req_ready, req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_set;
    logic [3:0]  req_blk, req_way, req_mask;
    logic        rd_valid;
    logic        sram_wen;
    logic [31:0] sram_data;
    logic [7:0]  sram_set;
    logic [3:0]  sram_blk, sram_way, sram_mask;
    logic [7:0]  fwd_set;
    logic [3:0]  fwd_blk, fwd_way;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;
    logic        empty;

    data_write_buffer #(.DEPTH(DEPTH), .DATA_W(32), .SET_W(8), .NBLK(4), .NWAY(4)) dut (
        .clock(clock), .reset(reset),
        .io_req_ready(req_ready), .io_req_valid(req_valid),
        .io_req_bits_data(req_data), .io_req_bits_set(req_set),
        .io_req_bits_blockSelOH(req_blk), .io_req_bits_way(req_way),
        .io_req_bits_mask(req_mask), .io_rd_valid(rd_valid),
        .io_sram_wen(sram_wen), .io_sram_data(sram_data), .io_sram_set(sram_set),
        .io_sram_blockSelOH(sram_blk), .io_sram_way(sram_way), .io_sram_mask(sram_mask),
        .io_fwd_set(fwd_set), .io_fwd_blockSelOH(fwd_blk), .io_fwd_way(fwd_way),
        .io_fwd_hit(fwd_hit), .io_fwd_data(fwd_data), .io_fwd_mask(fwd_mask),
        .io_empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [7:0]  s;
        logic [3:0]  b;
        logic [3:0]  w;
        logic [3:0]  m;
        logic        rd;
        logic [7:0]  ks;
        logic [3:0]  kb;
        logic [3:0]  kw;
        logic        e_rdy;
        logic        e_wen;
        logic        e_emp;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [3:0]  e_fm;
        logic        cs;
        logic [31:0] e_sd;
        logic [7:0]  e_ss;
        logic [3:0]  e_sb;
        logic [3:0]  e_sw;
        logic [3:0]  e_sm;
    } vec_t;

    vec_t vt [27];

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  s;
        logic [3:0]  b;
        logic [3:0]  w;
        logic [3:0]  m;
    } ent_t;

    ent_t mq[$];

    task automatic model_step(input int c);
        logic        e_rdy, e_wen, e_emp, e_hit, fire_m;
        logic [31:0] e_fd;
        logic [3:0]  e_fm;
        ent_t        t;
        int          n;
        n     = mq.size();
        e_rdy = (n != DEPTH);
        e_wen = (n != 0) && !rd_valid;
        e_emp = (n == 0);
        e_hit = 1'b0;
        e_fd  = '0;
        e_fm  = '0;
        for (int i = 0; i < n; i++) begin
            if (mq[i].s == fwd_set && mq[i].b == fwd_blk && mq[i].w == fwd_way) begin
                e_hit = 1'b1;
                e_fm  = e_fm | mq[i].m;
                for (int j = 0; j < 4; j++)
                    if (mq[i].m[j]) e_fd[j*8 +: 8] = mq[i].d[j*8 +: 8];
            end
        end
        chk($sformatf("rnd%0d ready", c), 64'(req_ready), 64'(e_rdy));
        chk($sformatf("rnd%0d wen", c), 64'(sram_wen), 64'(e_wen));
        chk($sformatf("rnd%0d empty", c), 64'(empty), 64'(e_emp));
        chk($sformatf("rnd%0d fwd_hit", c), 64'(fwd_hit), 64'(e_hit));
        chk($sformatf("rnd%0d fwd_data", c), 64'(fwd_data), 64'(e_fd));
        chk($sformatf("rnd%0d fwd_mask", c), 64'(fwd_mask), 64'(e_fm));
        if (e_wen)
            chk($sformatf("rnd%0d sram", c), 64'({sram_data, sram_set, sram_blk, sram_way, sram_mask}),
                64'(mq[0]));
        fire_m = req_valid && e_rdy;
        if (fire_m) begin
            if (n > 0 && mq[n-1].s == req_set && mq[n-1].b == req_blk && mq[n-1].w == req_way &&
                !(e_wen && n == 1)) begin
                t = mq[n-1];
                for (int j = 0; j < 4; j++)
                    if (req_mask[j]) t.d[j*8 +: 8] = req_data[j*8 +: 8];
                t.m = t.m | req_mask;
                mq[n-1] = t;
            end else begin
                mq.push_back({req_data, req_set, req_blk, req_way, req_mask});
            end
        end
        if (e_wen) void'(mq.pop_front());
    endtask

    initial begin
        logic [7:0] ks;
        logic [3:0] kb, kw;

        reset = 1'b0; req_valid = 1'b0; req_data = '0; req_set = '0; req_blk = '0;
        req_way = '0; req_mask = '0; rd_valid = 1'b0; fwd_set = '0; fwd_blk = '0; fwd_way = '0;

        // single write, immediate drain
        vt[0]  = '{1'b1, 32'hDEADBEEF, 8'h12, 4'h2, 4'h4, 4'hF, 1'b0, 8'h12, 4'h2, 4'h4,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        vt[1]  = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h12, 4'h2, 4'h4,
                   1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 8'h12, 4'h2, 4'h4, 4'hF};
        vt[2]  = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h12, 4'h2, 4'h4,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        // fill under read stall, reject when full, drain in order
        vt[3]  = '{1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF, 1'b1, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        vt[4]  = '{1'b1, 32'h22222222, 8'h21, 4'h1, 4'h1, 4'hF, 1'b1, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF};
        vt[5]  = '{1'b1, 32'h33333333, 8'h22, 4'h1, 4'h1, 4'hF, 1'b1, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF};
        vt[6]  = '{1'b1, 32'h44444444, 8'h23, 4'h1, 4'h1, 4'hF, 1'b1, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF};
        vt[7]  = '{1'b1, 32'h55555555, 8'h24, 4'h1, 4'h1, 4'hF, 1'b1, 8'h20, 4'h1, 4'h1,
                   1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF};
        vt[8]  = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h20, 4'h1, 4'h1,
                   1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 32'h11111111, 8'h20, 4'h1, 4'h1, 4'hF};
        vt[9]  = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h22222222, 8'h21, 4'h1, 4'h1, 4'hF};
        vt[10] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h33333333, 8'h22, 4'h1, 4'h1, 4'hF};
        vt[11] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h44444444, 8'h23, 4'h1, 4'h1, 4'hF};
        vt[12] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h20, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        // coalescing two halves of one word
        vt[13] = '{1'b1, 32'h0000AAAA, 8'h05, 4'h1, 4'h1, 4'h3, 1'b1, 8'h05, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        vt[14] = '{1'b1, 32'hBBBB0000, 8'h05, 4'h1, 4'h1, 4'hC, 1'b1, 8'h05, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h0000AAAA, 4'h3, 1'b1, 32'h0000AAAA, 8'h05, 4'h1, 4'h1, 4'h3};
        vt[15] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h05, 4'h1, 4'h1,
                   1'b1, 1'b1, 1'b0, 1'b1, 32'hBBBBAAAA, 4'hF, 1'b1, 32'hBBBBAAAA, 8'h05, 4'h1, 4'h1, 4'hF};
        vt[16] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h05, 4'h1, 4'h1,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        // same key twice with a different set between: youngest bytes win on forward
        vt[17] = '{1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1, 1'b1, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};
        vt[18] = '{1'b1, 32'h99999999, 8'h41, 4'h8, 4'h8, 4'hF, 1'b1, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h00000011, 4'h1, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[19] = '{1'b1, 32'h00002222, 8'h40, 4'h8, 4'h8, 4'h3, 1'b1, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h00000011, 4'h1, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[20] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b1, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h00002222, 4'h3, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[21] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b1, 8'h41, 4'h8, 4'h4,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[22] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b1, 8'h41, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h99999999, 4'hF, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[23] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b1, 1'b0, 1'b1, 32'h00002222, 4'h3, 1'b1, 32'h00000011, 8'h40, 4'h8, 4'h8, 4'h1};
        vt[24] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b1, 1'b0, 1'b1, 32'h00002222, 4'h3, 1'b1, 32'h99999999, 8'h41, 4'h8, 4'h8, 4'hF};
        vt[25] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b1, 1'b0, 1'b1, 32'h00002222, 4'h3, 1'b1, 32'h00002222, 8'h40, 4'h8, 4'h8, 4'h3};
        vt[26] = '{1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h40, 4'h8, 4'h8,
                   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 8'h0, 4'h0, 4'h0, 4'h0};

        @(negedge clock);
        chk("in-reset ready", 64'(req_ready), 64'(1'b1));
        chk("in-reset wen", 64'(sram_wen), 64'(1'b0));
        chk("in-reset empty", 64'(empty), 64'(1'b1));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 27; i++) begin
            req_valid = vt[i].v;  req_data = vt[i].d; req_set = vt[i].s;
            req_blk = vt[i].b;    req_way = vt[i].w;  req_mask = vt[i].m;
            rd_valid = vt[i].rd;  fwd_set = vt[i].ks; fwd_blk = vt[i].kb; fwd_way = vt[i].kw;
            @(negedge clock);
            chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d wen", i), 64'(sram_wen), 64'(vt[i].e_wen));
            chk($sformatf("vec%0d empty", i), 64'(empty), 64'(vt[i].e_emp));
            chk($sformatf("vec%0d fwd_hit", i), 64'(fwd_hit), 64'(vt[i].e_hit));
            chk($sformatf("vec%0d fwd_data", i), 64'(fwd_data), 64'(vt[i].e_fd));
            chk($sformatf("vec%0d fwd_mask", i), 64'(fwd_mask), 64'(vt[i].e_fm));
            if (vt[i].cs)
                chk($sformatf("vec%0d sram", i),
                    64'({sram_data, sram_set, sram_blk, sram_way, sram_mask}),
                    64'({vt[i].e_sd, vt[i].e_ss, vt[i].e_sb, vt[i].e_sw, vt[i].e_sm}));
            @(posedge clock); #1;
        end

        // asynchronous reset with two entries pending
        req_valid = 1'b1; req_data = 32'hCAFE0001; req_set = 8'h60; req_blk = 4'h1;
        req_way = 4'h1; req_mask = 4'hF; rd_valid = 1'b1;
        fwd_set = 8'h60; fwd_blk = 4'h1; fwd_way = 4'h1;
        @(posedge clock); #1;
        req_data = 32'hCAFE0002; req_set = 8'h61;
        @(posedge clock); #1;
        req_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk("pre-rst wen", 64'(sram_wen), 64'(1'b1));
        chk("pre-rst fwd_hit", 64'(fwd_hit), 64'(1'b1));
        reset = 1'b0;
        #1;
        chk("rst wen", 64'(sram_wen), 64'(1'b0));
        chk("rst empty", 64'(empty), 64'(1'b1));
        chk("rst ready", 64'(req_ready), 64'(1'b1));
        chk("rst fwd_hit", 64'(fwd_hit), 64'(1'b0));
        chk("rst fwd_mask", 64'(fwd_mask), 64'(4'h0));
        chk("rst fwd_data", 64'(fwd_data), 64'(32'h0));
        chk("rst sram_data", 64'(sram_data), 64'(32'h0));
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("post-rst%0d wen", i), 64'(sram_wen), 64'(1'b0));
            chk($sformatf("post-rst%0d empty", i), 64'(empty), 64'(1'b1));
        end
        @(posedge clock); #1;

        // randomized traffic; first phase keeps requests continuous with rd_valid toggling
        mq.delete();
        ks = 8'h0; kb = 4'h1; kw = 4'h1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) != 0) begin
                ks = 8'($urandom_range(0, 2));
                kb = 4'b0001 << $urandom_range(0, 1);
                kw = 4'b0001 << $urandom_range(0, 1);
            end
            req_set = ks; req_blk = kb; req_way = kw;
            req_data = $urandom;
            req_mask = 4'($urandom_range(1, 15));
            if (c < 400) begin
                req_valid = 1'b1;
                rd_valid  = ((c % 2) == 1);
            end else if (c < 1600) begin
                req_valid = ($urandom_range(0, 9) < 8);
                rd_valid  = ($urandom_range(0, 9) < 6);
            end else begin
                req_valid = ($urandom_range(0, 9) < 6);
                rd_valid  = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 1) == 0) begin
                fwd_set = ks; fwd_blk = kb; fwd_way = kw;
            end else begin
                fwd_set = 8'($urandom_range(0, 2));
                fwd_blk = 4'b0001 << $urandom_range(0, 1);
                fwd_way = 4'b0001 << $urandom_range(0, 1);
            end
            @(negedge clock);
            model_step(c);
            @(posedge clock); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
